descrambler_multilane: RTL and testbench
========================================

DESCRAMBLER_MULTILANE -- requirements
Module: descrambler_multilane

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of independent 64b/66b receive lanes (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, payload bits per lane per word (32 or 64).
REQ-003 SHALL have parameter SEED, default 58'h3FF_FFFF_FFFF_FFFF, reset value of every lane's descrambler state.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port data_in  input  NUM_LANES*DATA_WIDTH  scrambled payload; lane n occupies bits [n*DATA_WIDTH +: DATA_WIDTH]; bit 0 of a lane word is first received.
REQ-007 SHALL have port sync_in  input  NUM_LANES*2  sync header per lane, bits [2n +: 2].
REQ-008 SHALL have port valid_in  input  NUM_LANES  per-lane word strobe.
REQ-009 SHALL have port hdr_valid_in  input  NUM_LANES  sync_in meaningful this word (always 1 for DATA_WIDTH 64; every second word for 32).
REQ-010 SHALL have port bypass  input  1  pass payload undescrambled, all lanes.
REQ-011 SHALL have port cnt_clr  input  1  synchronous clear of all header-error counters.
REQ-012 SHALL have port data_out  output  NUM_LANES*DATA_WIDTH  descrambled payload, same lane packing.
REQ-013 SHALL have port sync_out  output  NUM_LANES*2  registered copy of sync_in.
REQ-014 SHALL have port valid_out  output  NUM_LANES  registered copy of valid_in.
REQ-015 SHALL have port hdr_err  output  NUM_LANES  one-cycle pulse per invalid header.
REQ-016 SHALL have port hdr_err_cnt  output  NUM_LANES*8  per-lane saturating invalid-header count.

Function
REQ-017 SHALL descramble with self-synchronising polynomial x^58+x^39+1: out[k] = in[k] ^ s[38] ^ s[57], then s = {s[56:0], in[k]}, k = 0..DATA_WIDTH-1 in order.
REQ-018 SHALL advance lane n state only in cycles where valid_in[n]=1; otherwise state, data_out, sync_out of that lane hold.
REQ-019 SHALL register outputs with exactly 1 cycle latency: valid_out[n] in cycle t+1 equals valid_in[n] in cycle t.
REQ-020 SHALL, when bypass=1 in the input cycle, output data_in unchanged while still advancing state, so clearing bypass yields correct data on the next word without reseed.
REQ-021 SHALL flag header invalid when valid_in[n] & hdr_valid_in[n] and sync_in lane value is 2'b00 or 2'b11; hdr_err[n] asserts with the corresponding valid_out.
REQ-022 SHALL increment hdr_err_cnt[n] per invalid header, saturating at 255 (no wrap).
REQ-023 SHALL give cnt_clr priority over a same-cycle increment (counter becomes 0).
REQ-024 SHALL keep lanes fully independent; no cross-lane state or gating.

Reset
REQ-025 SHALL on rst assert set data_out, sync_out, valid_out, hdr_err, hdr_err_cnt to 0 and every lane state to SEED, immediately and asynchronously.
REQ-026 SHALL on rst mid-stream discard in-flight words; first word accepted after deassertion descrambles from SEED.

Structure
REQ-027 SHALL place polynomial tap constants (38, 57), state width 58, SEED default and counter width 8 in shared package descrambler_pkg.
REQ-028 SHALL instantiate one sub-module descrambler_lane per lane (state, datapath, header check, counter); top is generate loop plus bypass fan-out.

Verification
REQ-029 SHALL cover: 4 lanes, payload 64'h0 scrambled by model seeded all-ones, 16 words -> data_out 0 every word, valid_out 1 cycle behind.
REQ-030 SHALL cover: bypass=1, data_in lane0 64'hDEADBEEF_CAFEF00D -> data_out lane0 identical next cycle; bypass=0 next word -> correct descrambled data.
REQ-031 SHALL cover: lane2 sync 2'b11 valid -> hdr_err[2] single pulse, hdr_err_cnt[2]=1, other lanes 0; 300 bad headers -> 255.
REQ-032 SHALL cover: cnt_clr with bad header same cycle -> counter 0; hdr_valid_in=0 with sync 2'b00 -> no error.
REQ-033 SHALL cover: valid_in low 5 cycles with random data_in mid-stream -> outputs hold; subsequent words match model.
REQ-034 SHALL cover: rst pulse asynchronous to clk mid-stream -> outputs 0 in same cycle; restarted model stream from SEED descrambles correctly.

Source files
------------

// File: rtl/descrambler_pkg.sv
// Shared constants for the multilane 64b/66b descrambler (x^58 + x^39 + 1).
package descrambler_pkg;

    localparam int STATE_W = 58;
    localparam int TAP_A   = 38;
    localparam int TAP_B   = 57;
    localparam logic [STATE_W-1:0] SEED_DEFAULT = 58'h3FF_FFFF_FFFF_FFFF;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // 2'b01 and 2'b10 are the only legal 64b/66b sync headers.
    function automatic logic hdr_bad(input logic [1:0] sync);
        return (sync == 2'b00) || (sync == 2'b11);
    endfunction

endpackage

// File: rtl/descrambler_lane.sv
// One receive lane: self-synchronising descrambler, header check, saturating error counter.
module descrambler_lane
    import descrambler_pkg::*;
#(
    parameter int                 DATA_WIDTH = 64,
    parameter logic [STATE_W-1:0] SEED       = SEED_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            sync_in,
    input  logic                  valid_in,
    input  logic                  hdr_valid_in,
    input  logic                  bypass,
    input  logic                  cnt_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            sync_out,
    output logic                  valid_out,
    output logic                  hdr_err,
    output logic [CNT_W-1:0]      hdr_err_cnt
);

    logic [STATE_W-1:0]    state;
    logic [STATE_W-1:0]    state_nxt;
    logic [DATA_WIDTH-1:0] plain;
    logic                  bad_hdr;

    always_comb begin
        // NOTE: blocking assignments let the loop unroll into a bit-serial shift chain;
        // both outputs get a default first so no latch is inferred.
        state_nxt = state;
        plain     = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            plain[k]  = data_in[k] ^ state_nxt[TAP_A] ^ state_nxt[TAP_B];
            state_nxt = {state_nxt[STATE_W-2:0], data_in[k]};
        end
    end

    assign bad_hdr = valid_in & hdr_valid_in & hdr_bad(sync_in);

    // State always absorbs the received bits, even in bypass, so leaving bypass needs no reseed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEED;
            data_out    <= '0;
            sync_out    <= '0;
            valid_out   <= 1'b0;
            hdr_err     <= 1'b0;
            hdr_err_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            valid_out <= valid_in;
            hdr_err   <= bad_hdr;
            if (valid_in) begin
                state    <= state_nxt;
                data_out <= bypass ? data_in : plain;
                sync_out <= sync_in;
            end
            if (cnt_clr) begin
                hdr_err_cnt <= '0;
            end else if (bad_hdr && (hdr_err_cnt != CNT_MAX)) begin
                hdr_err_cnt <= hdr_err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/descrambler_multilane.sv
// Top: NUM_LANES independent descrambler lanes sharing only clock, reset, bypass and counter clear.
module descrambler_multilane
    import descrambler_pkg::*;
#(
    parameter int                 NUM_LANES  = 4,
    parameter int                 DATA_WIDTH = 64,
    parameter logic [STATE_W-1:0] SEED       = SEED_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_LANES*2-1:0]          sync_in,
    input  logic [NUM_LANES-1:0]            valid_in,
    input  logic [NUM_LANES-1:0]            hdr_valid_in,
    input  logic                            bypass,
    input  logic                            cnt_clr,
    output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
    output logic [NUM_LANES*2-1:0]          sync_out,
    output logic [NUM_LANES-1:0]            valid_out,
    output logic [NUM_LANES-1:0]            hdr_err,
    output logic [NUM_LANES*CNT_W-1:0]      hdr_err_cnt
);

    logic [NUM_LANES-1:0] bypass_fan;
    logic [NUM_LANES-1:0] cnt_clr_fan;

    assign bypass_fan  = {NUM_LANES{bypass}};
    assign cnt_clr_fan = {NUM_LANES{cnt_clr}};

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        descrambler_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .SEED       (SEED)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .data_in      (data_in[n*DATA_WIDTH +: DATA_WIDTH]),
            .sync_in      (sync_in[2*n +: 2]),
            .valid_in     (valid_in[n]),
            .hdr_valid_in (hdr_valid_in[n]),
            .bypass       (bypass_fan[n]),
            .cnt_clr      (cnt_clr_fan[n]),
            .data_out     (data_out[n*DATA_WIDTH +: DATA_WIDTH]),
            .sync_out     (sync_out[2*n +: 2]),
            .valid_out    (valid_out[n]),
            .hdr_err      (hdr_err[n]),
            .hdr_err_cnt  (hdr_err_cnt[n*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_descrambler_multilane.sv
// Scoreboard bench: a transmit-side scrambler model feeds plaintext; the DUT must recover it.
module tb_descrambler_multilane;

    localparam int NL = 4;
    localparam int DW = 64;
    localparam logic [57:0] SEED_TB = 58'h3FF_FFFF_FFFF_FFFF;
    localparam logic [7:0]  GOOD    = 8'b01_10_01_10;

    logic            clk = 1'b0;
    logic            rst;
    logic [NL*DW-1:0] data_in;
    logic [NL*2-1:0]  sync_in;
    logic [NL-1:0]    valid_in;
    logic [NL-1:0]    hdr_valid_in;
    logic             bypass;
    logic             cnt_clr;
    logic [NL*DW-1:0] data_out;
    logic [NL*2-1:0]  sync_out;
    logic [NL-1:0]    valid_out;
    logic [NL-1:0]    hdr_err;
    logic [NL*8-1:0]  hdr_err_cnt;

    descrambler_multilane #(.NUM_LANES(NL), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .sync_in      (sync_in),
        .valid_in     (valid_in),
        .hdr_valid_in (hdr_valid_in),
        .bypass       (bypass),
        .cnt_clr      (cnt_clr),
        .data_out     (data_out),
        .sync_out     (sync_out),
        .valid_out    (valid_out),
        .hdr_err      (hdr_err),
        .hdr_err_cnt  (hdr_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL-1:0]    valid;
        logic [NL-1:0]    err;
        logic [NL*DW-1:0] data;
        logic [NL*2-1:0]  sync;
    } rec_t;

    rec_t             sb_q[$];
    int               checks   = 0;
    int               failures = 0;
    logic [57:0]      st[NL];
    logic [63:0]      plain[NL];
    logic [NL*DW-1:0] last_data;
    logic [NL*2-1:0]  last_sync;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void scramble(input logic [57:0] s_in, input logic [63:0] p,
                                     output logic [63:0] c, output logic [57:0] s_out);
        logic [57:0] s;
        s = s_in;
        c = '0;
        for (int k = 0; k < 64; k++) begin
            c[k] = p[k] ^ s[38] ^ s[57];
            s    = {s[56:0], c[k]};
        end
        s_out = s;
    endfunction

    function automatic logic [57:0] absorb(input logic [57:0] s_in, input logic [63:0] c);
        logic [57:0] s;
        s = s_in;
        for (int k = 0; k < 64; k++) s = {s[56:0], c[k]};
        return s;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NL; n++) st[n] = SEED_TB;
        last_data = '0;
        last_sync = '0;
    endtask

    // Drive one word; in bypass the plain[] value is transmitted raw and must come back unchanged.
    task automatic step(input logic [NL-1:0] vm, input logic [NL-1:0] hv, input logic [7:0] sy,
                        input logic byp, input logic clr);
        rec_t        r;
        logic [63:0] c;
        logic [57:0] s_new;
        r.err = '0;
        for (int n = 0; n < NL; n++) begin
            if (vm[n]) begin
                if (byp) begin
                    c     = plain[n];
                    st[n] = absorb(st[n], c);
                end else begin
                    scramble(st[n], plain[n], c, s_new);
                    st[n] = s_new;
                end
                data_in[n*DW +: DW]   = c;
                last_data[n*DW +: DW] = plain[n];
                last_sync[2*n +: 2]   = sy[2*n +: 2];
                r.err[n] = hv[n] && (sy[2*n +: 2] == 2'b00 || sy[2*n +: 2] == 2'b11);
            end else begin
                data_in[n*DW +: DW] = {$urandom, $urandom};
            end
        end
        sync_in      = sy;
        valid_in     = vm;
        hdr_valid_in = hv;
        bypass       = byp;
        cnt_clr      = clr;
        r.valid = vm;
        r.data  = last_data;
        r.sync  = last_sync;
        if (vm != '0) sb_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge clk);
            if (!rst && valid_out != '0) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected", 256'(valid_out), 256'(0));
                end else begin
                    r = sb_q.pop_front();
                    check("valid_out", 256'(valid_out), 256'(r.valid));
                    check("data_out", 256'(data_out), 256'(r.data));
                    check("sync_out", 256'(sync_out), 256'(r.sync));
                    check("hdr_err", 256'(hdr_err), 256'(r.err));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst = 1'b1; data_in = '0; sync_in = '0; valid_in = '0; hdr_valid_in = '0;
        bypass = 1'b0; cnt_clr = 1'b0;
        model_reset();
        #12;
        check("rst_data", 256'(data_out), 256'(0));
        check("rst_valid", 256'(valid_out), 256'(0));
        check("rst_sync", 256'(sync_out), 256'(0));
        check("rst_cnt", 256'(hdr_err_cnt), 256'(0));
        check("rst_err", 256'(hdr_err), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // All-zero payload stream from an all-ones scrambler must descramble to zero.
        for (int n = 0; n < NL; n++) plain[n] = 64'h0;
        for (int i = 0; i < 16; i++) step('1, '1, GOOD, 1'b0, 1'b0);

        // Bypass word, then normal descrambling resumes without reseed.
        plain[0] = 64'hDEADBEEF_CAFEF00D;
        for (int n = 1; n < NL; n++) plain[n] = 64'h1111_1111_1111_1111 * 64'(n);
        step('1, '1, GOOD, 1'b1, 1'b0);
        check("bypass_lane0", 256'(data_out[63:0]), 256'(64'hDEADBEEF_CAFEF00D));
        for (int n = 0; n < NL; n++) plain[n] = 64'h0123_4567_89AB_CDEF ^ 64'(n);
        step('1, '1, GOOD, 1'b0, 1'b0);
        check("post_bypass_lane0", 256'(data_out[63:0]), 256'(64'h0123_4567_89AB_CDEF));

        // Bad header on lane 2 only; then saturate its counter.
        step('1, '1, 8'b01_11_01_10, 1'b0, 1'b0);
        check("cnt_one", 256'(hdr_err_cnt), 256'(32'h0001_0000));
        step('1, '1, GOOD, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            plain[2] = 64'(i) * 64'h9E37_79B9_7F4A_7C15;
            step('1, '1, 8'b01_11_01_10, 1'b0, 1'b0);
        end
        check("cnt_sat", 256'(hdr_err_cnt), 256'(32'h00FF_0000));

        // Clear wins over a same-cycle increment; hdr_valid_in low masks a 2'b00 header.
        step('1, '1, 8'b01_11_01_10, 1'b0, 1'b1);
        check("cnt_clr", 256'(hdr_err_cnt), 256'(0));
        step('1, 4'b1011, 8'b01_00_01_10, 1'b0, 1'b0);
        check("hdr_masked", 256'(hdr_err_cnt), 256'(0));

        // Independent lane strobes.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < NL; n++) plain[n] = 64'hA5A5_0000_0000_5A5A + 64'(16 * i + n);
            step(4'b0101, 4'b0101, GOOD, 1'b0, 1'b0);
            step(4'b1010, 4'b1010, GOOD, 1'b0, 1'b0);
        end

        // Stall with random data on the line: outputs must hold.
        for (int i = 0; i < 5; i++) begin
            step('0, '0, 8'($urandom), 1'b0, 1'b0);
            check("hold_data", 256'(data_out), 256'(last_data));
            check("hold_sync", 256'(sync_out), 256'(last_sync));
            check("hold_valid", 256'(valid_out), 256'(0));
        end
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < NL; n++) plain[n] = 64'hFEDC_BA98_7654_3210 ^ (64'(i) << (8 * n));
            step('1, '1, (i == 3) ? 8'b01_10_00_10 : GOOD, 1'b0, 1'b0);
        end
        check("cnt_lane1", 256'(hdr_err_cnt), 256'(32'h0000_0100));

        // Asynchronous reset mid-cycle with a word in flight.
        @(negedge clk);
        #2;
        data_in  = {NL{64'h1234_5678_9ABC_DEF0}};
        sync_in  = 8'b11_11_11_11;
        valid_in = '1;
        hdr_valid_in = '1;
        #1 rst = 1'b1;
        #1;
        check("arst_data", 256'(data_out), 256'(0));
        check("arst_valid", 256'(valid_out), 256'(0));
        check("arst_sync", 256'(sync_out), 256'(0));
        check("arst_cnt", 256'(hdr_err_cnt), 256'(0));
        valid_in = '0;
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            for (int n = 0; n < NL; n++) plain[n] = 64'h0F0F_F0F0_3C3C_C3C3 + 64'(7 * i + n);
            step('1, '1, GOOD, 1'b0, 1'b0);
        end
        check("restart_lane3", 256'(data_out[255:192]), 256'(64'h0F0F_F0F0_3C3C_C3C3 + 64'(38)));

        step('0, '0, GOOD, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        check("sb_drain", 256'(sb_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
